// File: rtl/stream_sel_mux_pkg.sv
// Shared selector/arbiter definitions: mode encodings and the index-width helper
// used by the stream select mux and its round-robin arbiter.
package stream_sel_mux_pkg;

    localparam int SEL_MODE_EXPLICIT = 0;
    localparam int SEL_MODE_RR       = 1;

    // Width needed to index n channels, never less than one bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 << i) < n) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/stream_sel_mux_if.sv
// Handshake bundle of the N-channel stream selector: per-channel inputs,
// the registered output stream, and the select / error controls.
interface stream_sel_mux_if
    import stream_sel_mux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 4
);
    localparam int SEL_W = clog2_min1(N);

    logic [N-1:0]       in_valid;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_ready;
    logic [SEL_W-1:0]   sel;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [SEL_W-1:0]   out_chan;
    logic               out_ready;
    logic               sel_err;
    logic               clr_err;

    modport master (
        output in_valid, in_data, sel, out_ready, clr_err,
        input  in_ready, out_valid, out_data, out_chan, sel_err
    );

    modport slave (
        input  in_valid, in_data, sel, out_ready, clr_err,
        output in_ready, out_valid, out_data, out_chan, sel_err
    );

endinterface

// File: rtl/stream_sel_mux_rr_arbiter.sv
// Round-robin arbiter: grants the first requester after the last winner,
// wrapping modulo N; the pointer moves only when the caller strobes advance_i.
module rr_arbiter
    import stream_sel_mux_pkg::*;
#(
    parameter int  N     = 4,
    localparam int SEL_W = clog2_min1(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req_i,
    input  logic             advance_i,
    output logic [N-1:0]     grant_oh_o,
    output logic [SEL_W-1:0] grant_idx_o,
    output logic             grant_vld_o
);

    localparam logic [SEL_W-1:0] PTR_RST  = SEL_W'(N - 1);
    localparam logic [N-1:0]     ONE_HOT0 = {{(N - 1){1'b0}}, 1'b1};

    logic [SEL_W-1:0] ptr_q;
    logic [SEL_W-1:0] ptr_d;
    logic [SEL_W-1:0] hi_idx_s;
    logic [SEL_W-1:0] lo_idx_s;
    logic             hi_vld_s;
    logic             lo_vld_s;

    // Lowest requester above the pointer, else lowest requester overall (wrap).
    always_comb begin
        hi_idx_s = '0;
        lo_idx_s = '0;
        hi_vld_s = 1'b0;
        lo_vld_s = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                lo_idx_s = SEL_W'(i);
                lo_vld_s = 1'b1;
            end else begin
                lo_idx_s = lo_idx_s;
            end
            if (req_i[i] && (i > int'(ptr_q))) begin
                hi_idx_s = SEL_W'(i);
                hi_vld_s = 1'b1;
            end else begin
                hi_idx_s = hi_idx_s;
            end
        end
    end

    // Grant outputs and pointer next state.
    always_comb begin
        grant_vld_o = lo_vld_s;
        grant_idx_o = hi_vld_s ? hi_idx_s : lo_idx_s;
        grant_oh_o  = lo_vld_s ? (ONE_HOT0 << grant_idx_o) : '0;
        if (advance_i && lo_vld_s) begin
            ptr_d = grant_idx_o;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register; reset to N-1 so channel 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= PTR_RST;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/stream_sel_mux.sv
// N-channel registered stream selector with explicit-select or round-robin
// grant, a one-entry output register and a sticky illegal-select flag.
module stream_sel_mux
    import stream_sel_mux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int MODE  = SEL_MODE_EXPLICIT
) (
    input logic             clk,
    input logic             rst_n,
    stream_sel_mux_if.slave bus
);

    localparam int           SEL_W    = clog2_min1(N);
    localparam logic [N-1:0] ONE_HOT0 = {{(N - 1){1'b0}}, 1'b1};

    logic             out_valid_q;
    logic             out_valid_d;
    logic [WIDTH-1:0] out_data_q;
    logic [WIDTH-1:0] out_data_d;
    logic [SEL_W-1:0] out_chan_q;
    logic [SEL_W-1:0] out_chan_d;
    logic             sel_err_q;
    logic             sel_err_d;

    logic             can_load_s;
    logic             grant_vld_s;
    logic [SEL_W-1:0] grant_idx_s;
    logic [N-1:0]     grant_oh_s;
    logic [N-1:0]     ready_s;
    logic             xfer_s;
    logic             sel_set_s;
    logic [WIDTH-1:0] load_data_s;

    generate
        if (MODE == SEL_MODE_RR) begin : g_rr
            logic unused_sel_s;

            rr_arbiter #(.N(N)) u_arb (
                .clk         (clk),
                .rst_n       (rst_n),
                .req_i       (bus.in_valid),
                .advance_i   (xfer_s),
                .grant_oh_o  (grant_oh_s),
                .grant_idx_o (grant_idx_s),
                .grant_vld_o (grant_vld_s)
            );

            assign unused_sel_s = ^bus.sel;
            assign sel_set_s    = 1'b0;
        end else begin : g_sel
            localparam logic [SEL_W:0] N_W = (SEL_W + 1)'(N);

            // Explicit select: grant follows sel whenever it names a real channel.
            always_comb begin
                grant_vld_s = ({1'b0, bus.sel} < N_W);
                grant_idx_s = bus.sel;
                grant_oh_s  = grant_vld_s ? (ONE_HOT0 << bus.sel) : '0;
                sel_set_s   = !grant_vld_s && (|bus.in_valid);
            end
        end
    endgenerate

    // Handshake: ready is held low during reset and while the output is stalled.
    always_comb begin
        can_load_s  = rst_n && (!out_valid_q || bus.out_ready);
        ready_s     = can_load_s ? grant_oh_s : '0;
        xfer_s      = |(bus.in_valid & ready_s);
        load_data_s = '0;
        for (int i = 0; i < N; i++) begin
            load_data_s = load_data_s | ({WIDTH{grant_oh_s[i]}} & bus.in_data[i*WIDTH +: WIDTH]);
        end
    end

    // Output register and sticky error next state; a set beats a same-cycle clear.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        if (xfer_s) begin
            out_valid_d = 1'b1;
            out_data_d  = load_data_s;
            out_chan_d  = grant_idx_s;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        if (sel_set_s) begin
            sel_err_d = 1'b1;
        end else if (bus.clr_err) begin
            sel_err_d = 1'b0;
        end else begin
            sel_err_d = sel_err_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            sel_err_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign bus.in_ready  = ready_s;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_chan  = out_chan_q;
    assign bus.sel_err   = sel_err_q;

endmodule

// File: tb/tb_stream_sel_mux.sv
// Self-checking bench for stream_sel_mux: explicit-select and round-robin
// configurations driven from vector tables, scoreboard queues and random traffic.
module tb_stream_sel_mux;
    import stream_sel_mux_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stream_sel_mux_if #(.WIDTH(32), .N(4)) if0 ();
    stream_sel_mux_if #(.WIDTH(32), .N(3)) if1 ();
    stream_sel_mux_if #(.WIDTH(32), .N(4)) if2 ();
    stream_sel_mux_if #(.WIDTH(8),  .N(2)) if3 ();

    stream_sel_mux #(.WIDTH(32), .N(4), .MODE(SEL_MODE_EXPLICIT)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    stream_sel_mux #(.WIDTH(32), .N(3), .MODE(SEL_MODE_EXPLICIT)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    stream_sel_mux #(.WIDTH(32), .N(4), .MODE(SEL_MODE_RR))       u2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    stream_sel_mux #(.WIDTH(8),  .N(2), .MODE(SEL_MODE_RR))       u3 (.clk(clk), .rst_n(rst_n), .bus(if3));

    typedef struct {
        logic [3:0]  sel;
        logic [3:0]  vld;
        logic        ordy;
        logic [31:0] d;
        logic [3:0]  rdy;
        logic        ov;
        logic        xfer;
        logic [3:0]  ch;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  ch;
    } sb_t;

    int   total = 0;
    int   bad   = 0;
    sb_t  sbq[$];
    vec_t vt0[$];
    vec_t vt2[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] sel, input logic [3:0] vld, input logic ordy,
                                input logic [31:0] d, input logic [3:0] rdy, input logic ov,
                                input logic xfer, input logic [3:0] ch);
        vec_t v;
        v.sel = sel; v.vld = vld; v.ordy = ordy; v.d = d;
        v.rdy = rdy; v.ov = ov; v.xfer = xfer; v.ch = ch;
        return v;
    endfunction

    task automatic idle_all();
        if0.in_valid = '0; if0.in_data = '0; if0.sel = '0; if0.out_ready = 1'b0; if0.clr_err = 1'b0;
        if1.in_valid = '0; if1.in_data = '0; if1.sel = '0; if1.out_ready = 1'b0; if1.clr_err = 1'b0;
        if2.in_valid = '0; if2.in_data = '0; if2.sel = '0; if2.out_ready = 1'b0; if2.clr_err = 1'b0;
        if3.in_valid = '0; if3.in_data = '0; if3.sel = '0; if3.out_ready = 1'b0; if3.clr_err = 1'b0;
    endtask

    // One table vector on u0 (rr=0) or u2 (rr=1); output checked against the scoreboard head.
    task automatic run_vec(input bit rr, input vec_t v, input int k);
        logic [3:0]  rdy;
        logic        ov;
        logic [31:0] od;
        logic [1:0]  oc;
        string       tag;
        tag = $sformatf("%s[%0d]", rr ? "rr" : "sel", k);
        @(negedge clk);
        if (!rr) begin
            if0.sel = v.sel[1:0]; if0.in_valid = v.vld; if0.out_ready = v.ordy;
            for (int i = 0; i < 4; i++) if0.in_data[i*32 +: 32] = (i == int'(v.sel)) ? v.d : ~v.d;
        end else begin
            if2.sel = v.sel[1:0]; if2.in_valid = v.vld; if2.out_ready = v.ordy;
            for (int i = 0; i < 4; i++) if2.in_data[i*32 +: 32] = v.d + 32'(i);
        end
        #1;
        if (!rr) begin
            rdy = if0.in_ready; ov = if0.out_valid; od = if0.out_data; oc = if0.out_chan;
        end else begin
            rdy = if2.in_ready; ov = if2.out_valid; od = if2.out_data; oc = if2.out_chan;
        end
        chk({tag, " in_ready"}, 64'(rdy), 64'(v.rdy));
        chk({tag, " out_valid"}, 64'(ov), 64'(v.ov));
        if (ov) begin
            if (sbq.size() == 0) begin
                total++; bad++;
                $display("FAIL %s unexpected output: got %0h expected none", tag, od);
            end else begin
                chk({tag, " out_data"}, 64'(od), 64'(sbq[0].d));
                chk({tag, " out_chan"}, 64'(oc), 64'(sbq[0].ch));
                if (v.ordy) void'(sbq.pop_front());
            end
        end
        if (v.xfer) sbq.push_back('{d: (rr ? v.d + 32'(v.ch) : v.d), ch: v.ch});
    endtask

    logic [6:0] src_seq [2];
    logic [6:0] exp_seq [2];
    logic       src_vld [2];
    int         sent    [2];
    int         rcvd    [2];

    // One random-traffic cycle on the N=2, WIDTH=8 round-robin instance.
    task automatic rand_cycle(input int cyc, input bit drain);
        int c;
        @(negedge clk);
        if3.out_ready = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
        for (int j = 0; j < 2; j++) begin
            if (!src_vld[j] && !drain) src_vld[j] = ((cyc % 2) == j) || ($urandom_range(0, 3) == 0);
            if3.in_valid[j] = src_vld[j];
            if3.in_data[j*8 +: 8] = {1'(j), src_seq[j]};
        end
        #1;
        chk($sformatf("rand[%0d] ready onehot0", cyc), 64'($onehot0(if3.in_ready)), 64'd1);
        if (if3.out_valid && if3.out_ready) begin
            c = int'(if3.out_chan);
            chk($sformatf("rand[%0d] ch%0d data", cyc, c), 64'(if3.out_data), 64'({1'(c), exp_seq[c]}));
            exp_seq[c] = exp_seq[c] + 7'd1;
            rcvd[c]++;
        end
        for (int j = 0; j < 2; j++) begin
            if (src_vld[j] && if3.in_ready[j]) begin
                src_seq[j] = src_seq[j] + 7'd1;
                src_vld[j] = 1'b0;
                sent[j]++;
            end
        end
    endtask

    initial begin
        // explicit-select table (N=4): first load, 8-word stream, idle, stall with sel toggling, release
        vt0.push_back(mk(4'd2, 4'b0100, 1'b1, 32'hDEADBEEF, 4'b0100, 1'b0, 1'b1, 4'd2));
        for (int k = 1; k <= 8; k++)
            vt0.push_back(mk(4'd1, 4'b0010, 1'b1, 32'(k), 4'b0010, 1'b1, 1'b1, 4'd1));
        vt0.push_back(mk(4'd1, 4'b0000, 1'b1, 32'h0, 4'b0010, 1'b1, 1'b0, 4'd1));
        vt0.push_back(mk(4'd0, 4'b0000, 1'b1, 32'h0, 4'b0001, 1'b0, 1'b0, 4'd0));
        vt0.push_back(mk(4'd3, 4'b1000, 1'b0, 32'hA5A5A5A5, 4'b1000, 1'b0, 1'b1, 4'd3));
        for (int s = 0; s < 5; s++)
            vt0.push_back(mk(4'(s % 4), 4'b1111, 1'b0, 32'h5555_0000 + 32'(s), 4'b0000, 1'b1, 1'b0, 4'(s % 4)));
        vt0.push_back(mk(4'd1, 4'b1111, 1'b1, 32'h0000_0077, 4'b0010, 1'b1, 1'b1, 4'd1));
        vt0.push_back(mk(4'd0, 4'b0000, 1'b1, 32'h0, 4'b0001, 1'b1, 1'b0, 4'd0));
        vt0.push_back(mk(4'd0, 4'b0000, 1'b0, 32'h0, 4'b0001, 1'b0, 1'b0, 4'd0));

        // round-robin table (N=4): fairness, channels 1/3 only, pointer held across stall, wrap
        for (int k = 0; k < 8; k++)
            vt2.push_back(mk(4'd3, 4'b1111, 1'b1, 32'hC0DE_0000 + 32'(k * 16), 4'b0001 << (k % 4),
                             (k > 0), 1'b1, 4'(k % 4)));
        for (int k = 0; k < 4; k++)
            vt2.push_back(mk(4'd3, 4'b1010, 1'b1, 32'hBEE0_0000 + 32'(k * 16),
                             (k % 2 == 0) ? 4'b0010 : 4'b1000, 1'b1, 1'b1, (k % 2 == 0) ? 4'd1 : 4'd3));
        vt2.push_back(mk(4'd3, 4'b0000, 1'b1, 32'h0, 4'b0000, 1'b1, 1'b0, 4'd0));
        vt2.push_back(mk(4'd3, 4'b0100, 1'b1, 32'hF00D_0000, 4'b0100, 1'b0, 1'b1, 4'd2));
        for (int k = 0; k < 3; k++)
            vt2.push_back(mk(4'd3, 4'b1111, 1'b0, 32'h0BAD_0000, 4'b0000, 1'b1, 1'b0, 4'd0));
        vt2.push_back(mk(4'd3, 4'b1111, 1'b1, 32'hF00D_0100, 4'b1000, 1'b1, 1'b1, 4'd3));
        vt2.push_back(mk(4'd3, 4'b1111, 1'b1, 32'hF00D_0200, 4'b0001, 1'b1, 1'b1, 4'd0));
        vt2.push_back(mk(4'd3, 4'b0000, 1'b1, 32'h0, 4'b0000, 1'b1, 1'b0, 4'd0));
        vt2.push_back(mk(4'd3, 4'b0000, 1'b0, 32'h0, 4'b0000, 1'b0, 1'b0, 4'd0));

        idle_all();
        #2;
        chk("reset u0 out_valid", 64'(if0.out_valid), 64'd0);
        chk("reset u0 in_ready", 64'(if0.in_ready), 64'd0);
        chk("reset u1 sel_err", 64'(if1.sel_err), 64'd0);
        chk("reset u2 out_chan", 64'(if2.out_chan), 64'd0);
        chk("reset u3 out_data", 64'(if3.out_data), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // load a word on channel 1, then hit reset while it is held
        if0.sel = 2'd1; if0.in_valid = 4'b0010; if0.out_ready = 1'b0;
        if0.in_data[32 +: 32] = 32'h0000_1234;
        #1;
        chk("pre-reset in_ready", 64'(if0.in_ready), 64'b0010);
        @(negedge clk);
        #1;
        chk("pre-reset out_valid", 64'(if0.out_valid), 64'd1);
        chk("pre-reset out_data", 64'(if0.out_data), 64'h1234);
        if0.out_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset out_valid", 64'(if0.out_valid), 64'd0);
        chk("async reset out_data", 64'(if0.out_data), 64'd0);
        chk("async reset out_chan", 64'(if0.out_chan), 64'd0);
        chk("async reset in_ready", 64'(if0.in_ready), 64'd0);
        @(negedge clk);
        idle_all();
        rst_n = 1'b1;

        for (int k = 0; k < vt0.size(); k++) run_vec(1'b0, vt0[k], k);
        chk("sel scoreboard drained", 64'(sbq.size()), 64'd0);
        sbq.delete();

        // illegal select on the N=3 instance
        @(negedge clk);
        if1.in_data = {32'h0000_0102, 32'h0000_0101, 32'h0000_0100};
        if1.sel = 2'd3; if1.in_valid = 3'b111; if1.out_ready = 1'b1; if1.clr_err = 1'b0;
        #1;
        chk("bad sel in_ready", 64'(if1.in_ready), 64'd0);
        chk("bad sel err before edge", 64'(if1.sel_err), 64'd0);
        @(negedge clk);
        if1.sel = 2'd2;
        #1;
        chk("bad sel err set", 64'(if1.sel_err), 64'd1);
        chk("bad sel no transfer", 64'(if1.out_valid), 64'd0);
        chk("max sel in_ready", 64'(if1.in_ready), 64'b100);
        @(negedge clk);
        if1.sel = 2'd0; if1.in_valid = 3'b000; if1.clr_err = 1'b1;
        #1;
        chk("max sel out_data", 64'(if1.out_data), 64'h102);
        chk("max sel out_chan", 64'(if1.out_chan), 64'd2);
        chk("err held while legal", 64'(if1.sel_err), 64'd1);
        @(negedge clk);
        if1.sel = 2'd3; if1.in_valid = 3'b111; if1.clr_err = 1'b1;
        #1;
        chk("clr_err clears", 64'(if1.sel_err), 64'd0);
        @(negedge clk);
        if1.in_valid = 3'b000; if1.clr_err = 1'b0;
        #1;
        chk("set beats clear", 64'(if1.sel_err), 64'd1);
        @(negedge clk);
        if1.clr_err = 1'b1;
        #1;
        chk("err sticky without clr", 64'(if1.sel_err), 64'd1);
        @(negedge clk);
        if1.clr_err = 1'b0; if1.sel = 2'd0;
        #1;
        chk("err cleared idle", 64'(if1.sel_err), 64'd0);

        for (int k = 0; k < vt2.size(); k++) run_vec(1'b1, vt2[k], k);
        chk("rr scoreboard drained", 64'(sbq.size()), 64'd0);
        chk("rr sel_err constant", 64'(if2.sel_err), 64'd0);

        for (int j = 0; j < 2; j++) begin
            src_seq[j] = 7'd0; exp_seq[j] = 7'd0; src_vld[j] = 1'b0; sent[j] = 0; rcvd[j] = 0;
        end
        for (int cyc = 0; cyc < 300; cyc++) rand_cycle(cyc, 1'b0);
        for (int cyc = 300; cyc < 304; cyc++) rand_cycle(cyc, 1'b1);
        for (int j = 0; j < 2; j++) begin
            chk($sformatf("rand ch%0d sent vs received", j), 64'(rcvd[j]), 64'(sent[j]));
            chk($sformatf("rand ch%0d source drained", j), 64'(src_vld[j]), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
